// File: rtl/disp_pkg.sv
// ----------------------------------------------------------------------------
// disp_pkg
//   Shared types and constants for the display VRAM read master: the read FSM
//   state encoding, the fixed AXI4 read-address field values, and the frame
//   geometry from which the number of bursts per frame is derived.
// ----------------------------------------------------------------------------
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for a frame-start pulse
        WAIT = 2'd1,   // between bursts, waiting for FIFO room
        ADDR = 2'd2,   // read address presented, waiting for ARREADY
        DATA = 2'd3    // accepting read beats until RLAST
    } state_t;

    // Default frame geometry: 640x480, 32 bpp, two pixels per 64-bit beat.
    localparam int H_PIXELS_DEF   = 640;
    localparam int V_LINES_DEF    = 480;
    localparam int BURST_LEN_DEF  = 16;
    localparam int BEAT_BYTES_DEF = 8;

    // Fixed AXI read-address attributes.
    localparam logic [2:0] ARSIZE_8B    = 3'b011;
    localparam logic [1:0] ARBURST_INCR = 2'b01;

    // Burst counter width; large enough for the default 9600 bursts per frame.
    localparam int CNT_W = 14;

    // Bursts per frame. The geometry is expected to divide exactly.
    function automatic int calc_nburst(input int h_pixels, input int v_lines,
                                       input int burst_len);
        return h_pixels * v_lines / 2 / burst_len;
    endfunction

    localparam int NBURST      = calc_nburst(H_PIXELS_DEF, V_LINES_DEF, BURST_LEN_DEF);
    localparam int BURST_BYTES = BURST_LEN_DEF * BEAT_BYTES_DEF;

endpackage

// File: rtl/disp_vramrd.sv
// ----------------------------------------------------------------------------
// disp_vramrd
//   VRAM read master for the display path. Each frame-start pulse (while the
//   display is enabled) walks one frame of VRAM as AXI4 INCR read bursts and
//   writes every returned 64-bit beat into the display FIFO. A burst is only
//   requested once the FIFO reports room for a whole burst, so the R channel
//   is never back-pressured.
//
// Ports
//   ACLK, ARST          clock; synchronous active-high reset
//   DISPON              display enable; frames start only while high
//   VRSTART             one-cycle frame-start pulse
//   DISPADDR[31:0]      frame base byte address (bits [6:0] ignored)
//   BUF_WREADY          FIFO has room for at least one burst
//   FIFOIN[63:0]/FIFOWR registered beat data and write strobe to the FIFO
//   AR*                 AXI4 read-address channel (master side)
//   RDATA/RVALID/RLAST/RREADY  AXI4 read-data channel (master side)
//   BUSY                high from frame start until the frame's last beat
//                       has been written
// ----------------------------------------------------------------------------
module disp_vramrd
    import disp_pkg::*;
#(
    parameter int H_PIXELS   = H_PIXELS_DEF,
    parameter int V_LINES    = V_LINES_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int BEAT_BYTES = BEAT_BYTES_DEF
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic        DISPON,
    input  logic        VRSTART,
    input  logic [31:0] DISPADDR,
    input  logic        BUF_WREADY,
    output logic [63:0] FIFOIN,
    output logic        FIFOWR,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [63:0] RDATA,
    input  logic        RVALID,
    input  logic        RLAST,
    output logic        RREADY,
    output logic        BUSY
);

    localparam int FRAME_BURSTS = calc_nburst(H_PIXELS, V_LINES, BURST_LEN);
    localparam int STEP_BYTES   = BURST_LEN * BEAT_BYTES;

    state_t             state_q;
    logic [31:0]        araddr_q;
    logic               arvalid_q;
    logic               rready_q;
    logic               fifowr_q;
    logic [63:0]        fifoin_q;
    logic               busy_q;
    logic [CNT_W-1:0]   burst_cnt_q;

    logic [31:0]        araddr_d;
    logic               last_burst;

    // Bursts are 128-byte aligned; the low address bits are deliberately dropped.
    logic dispaddr_lsb_unused;
    assign dispaddr_lsb_unused = ^DISPADDR[6:0];

    // Next burst address; wraps modulo 2^32 by construction.
    assign araddr_d   = araddr_q + 32'(STEP_BYTES);
    assign last_burst = (burst_cnt_q == CNT_W'(FRAME_BURSTS - 1));

    always_ff @(posedge ACLK) begin
        // NOTE: every register here uses <= so all of them update from the same
        // pre-edge values; mixing in = would make results depend on statement order.
        if (ARST) begin
            state_q     <= IDLE;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            fifowr_q    <= 1'b0;
            fifoin_q    <= '0;
            busy_q      <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            // FIFOWR is a one-cycle pulse per accepted beat.
            fifowr_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // Entered right after the final beat is accepted, so BUSY
                    // drops on the same edge as the final FIFOWR.
                    busy_q <= 1'b0;
                    if (VRSTART && DISPON) begin
                        araddr_q    <= {DISPADDR[31:7], 7'b0};
                        burst_cnt_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= WAIT;
                    end
                end

                WAIT: begin
                    if (!DISPON) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (BUF_WREADY) begin
                        arvalid_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end

                ADDR: begin
                    // ARVALID/ARADDR are registers and simply hold until ARREADY.
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= DATA;
                    end
                end

                DATA: begin
                    if (RVALID) begin
                        fifoin_q <= RDATA;
                        fifowr_q <= 1'b1;
                        // RLAST alone ends the burst, however many beats arrived.
                        if (RLAST) begin
                            rready_q    <= 1'b0;
                            araddr_q    <= araddr_d;
                            burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                            // A DISPON drop mid-burst is handled in WAIT.
                            state_q     <= last_burst ? IDLE : WAIT;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign FIFOIN  = fifoin_q;
    assign FIFOWR  = fifowr_q;
    assign ARADDR  = araddr_q;
    assign ARLEN   = 8'(BURST_LEN - 1);
    assign ARSIZE  = ARSIZE_8B;
    assign ARBURST = ARBURST_INCR;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_disp_vramrd.sv
// ----------------------------------------------------------------------------
// tb_disp_vramrd
//   Scoreboard bench for disp_vramrd on a reduced 64x8 frame (16 bursts).
//   The stimulus process queues the expected burst addresses of each frame;
//   a randomized AXI slave answers the read channel and queues every beat it
//   hands over; monitors pop and compare whenever the DUT issues an address
//   or writes the FIFO.
// ----------------------------------------------------------------------------
module tb_disp_vramrd;
    import disp_pkg::*;

    localparam int TB_H   = 64;
    localparam int TB_V   = 8;
    localparam int TB_BL  = 16;
    localparam int TB_BB  = 8;
    localparam int TB_N   = TB_H * TB_V / 2 / TB_BL;
    localparam int STEP   = TB_BL * TB_BB;
    localparam int BUDGET = 4000;

    logic        ACLK = 1'b0;
    logic        ARST = 1'b1;
    logic        DISPON = 1'b0;
    logic        VRSTART = 1'b0;
    logic [31:0] DISPADDR = '0;
    logic        BUF_WREADY = 1'b1;
    logic        ARREADY = 1'b0;
    logic [63:0] RDATA = '0;
    logic        RVALID = 1'b0;
    logic        RLAST = 1'b0;
    logic [63:0] FIFOIN;
    logic        FIFOWR;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        RREADY;
    logic        BUSY;

    disp_vramrd #(
        .H_PIXELS  (TB_H),
        .V_LINES   (TB_V),
        .BURST_LEN (TB_BL),
        .BEAT_BYTES(TB_BB)
    ) dut (
        .ACLK      (ACLK),
        .ARST      (ARST),
        .DISPON    (DISPON),
        .VRSTART   (VRSTART),
        .DISPADDR  (DISPADDR),
        .BUF_WREADY(BUF_WREADY),
        .FIFOIN    (FIFOIN),
        .FIFOWR    (FIFOWR),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARSIZE    (ARSIZE),
        .ARBURST   (ARBURST),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RDATA     (RDATA),
        .RVALID    (RVALID),
        .RLAST     (RLAST),
        .RREADY    (RREADY),
        .BUSY      (BUSY)
    );

    always #5 ACLK = ~ACLK;

    // Scoreboard state
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_addr[$];
    logic [63:0] exp_data[$];

    // Slave / monitor bookkeeping (running totals, never reset)
    int          ar_delay = 0;
    bit          rgap_en = 1'b0;
    int          ar_wait = 0;
    logic [31:0] ar_held = '0;
    int          rd_pending = 0;
    int          beat = 0;
    int          ar_total = 0;
    int          r_total = 0;
    int          wr_total = 0;
    logic [31:0] ar_last_seen = '0;

    // Per-frame snapshots taken by the stimulus process
    int          ar_base = 0;
    int          r_base = 0;
    int          wr_base = 0;
    logic [31:0] frame_last = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input string why);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, why);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    // ---------------- AXI slave + AR-channel monitor (negedge) ----------------
    always @(negedge ACLK) begin
        if (ARST) begin
            ARREADY    = 1'b0;
            RVALID     = 1'b0;
            RLAST      = 1'b0;
            ar_wait    = 0;
            rd_pending = 0;
            beat       = 0;
        end else begin
            if (ARVALID) begin
                if (ar_wait > 0)
                    check("araddr_hold", 64'(ARADDR), 64'(ar_held));
                else
                    ar_held = ARADDR;
                ARREADY = (ar_wait >= ar_delay);
                if (ARREADY) begin
                    if (exp_addr.size() == 0)
                        note_fail("ar_unexpected", $sformatf("burst at 0x%0h not expected", ARADDR));
                    else
                        check("ar_addr", 64'(ARADDR), 64'(exp_addr.pop_front()));
                    ar_last_seen = ARADDR;
                    ar_total++;
                    rd_pending++;
                    ar_wait = 0;
                end else begin
                    ar_wait++;
                end
            end else begin
                if (ar_wait > 0)
                    note_fail("arvalid_drop", "ARVALID fell before ARREADY");
                ARREADY = 1'b0;
                ar_wait = 0;
            end

            // R channel: hold an unaccepted beat, otherwise maybe present a new one.
            if (RVALID && !RREADY) begin
                // beat still on the bus
            end else if (rd_pending > 0 && (!rgap_en || $urandom_range(0, 3) != 0)) begin
                RVALID = 1'b1;
                RDATA  = {$urandom, $urandom};
                RLAST  = (beat == TB_BL - 1);
            end else begin
                RVALID = 1'b0;
                RLAST  = 1'b0;
            end
            if (RVALID && RREADY) begin
                exp_data.push_back(RDATA);
                r_total++;
                beat++;
                if (RLAST) begin
                    beat = 0;
                    rd_pending--;
                end
            end
        end
    end

    // ---------------- FIFO write monitor (negedge) ----------------
    always @(negedge ACLK) begin
        if (FIFOWR) begin
            wr_total++;
            if (exp_data.size() == 0)
                note_fail("fifo_extra", $sformatf("unexpected write 0x%0h", FIFOIN));
            else
                check("fifoin", FIFOIN, exp_data.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_frame(input logic [31:0] base);
        logic [31:0] aligned;
        aligned  = base & 32'hFFFF_FF80;
        DISPADDR = base;
        DISPON   = 1'b1;
        VRSTART  = 1'b1;
        ar_base  = ar_total;
        r_base   = r_total;
        wr_base  = wr_total;
        for (int k = 0; k < TB_N; k++)
            exp_addr.push_back(aligned + 32'(k * STEP));
        frame_last = aligned + 32'((TB_N - 1) * STEP);
        tick();
        VRSTART = 1'b0;
        check("busy_rise", 64'(BUSY), 64'd1);
    endtask

    task automatic wait_busy_low(input string name);
        int n;
        n = 0;
        while (BUSY && n < BUDGET) begin
            tick();
            n++;
        end
        if (BUSY) note_fail(name, "BUSY still high after cycle budget");
    endtask

    task automatic wait_ar_count(input int target, input string name);
        int n;
        n = 0;
        while ((ar_total - ar_base) < target && n < BUDGET) begin
            tick();
            n++;
        end
        if ((ar_total - ar_base) < target) note_fail(name, "burst never issued");
    endtask

    task automatic check_frame_done(input string tag);
        check({tag, "_busy"}, 64'(BUSY), 64'd0);
        check({tag, "_state"}, 64'(dut.state_q), 64'(IDLE));
        check({tag, "_bursts"}, 64'(ar_total - ar_base), 64'(TB_N));
        check({tag, "_writes"}, 64'(wr_total - wr_base), 64'(TB_N * TB_BL));
        check({tag, "_last_addr"}, 64'(ar_last_seen), 64'(frame_last));
        check({tag, "_addr_left"}, 64'(exp_addr.size()), 64'd0);
        check({tag, "_data_left"}, 64'(exp_data.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arvalid"}, 64'(ARVALID), 64'd0);
        check({tag, "_rready"}, 64'(RREADY), 64'd0);
        check({tag, "_fifowr"}, 64'(FIFOWR), 64'd0);
        check({tag, "_fifoin"}, FIFOIN, 64'd0);
        check({tag, "_araddr"}, 64'(ARADDR), 64'd0);
        check({tag, "_busy"}, 64'(BUSY), 64'd0);
        check({tag, "_state"}, 64'(dut.state_q), 64'(IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [31:0] base;

        repeat (3) tick();
        check_reset_outputs("por");
        check("arlen", 64'(ARLEN), 64'(TB_BL - 1));
        check("arsize", 64'(ARSIZE), 64'd3);
        check("arburst", 64'(ARBURST), 64'd1);
        ARST = 1'b0;
        tick();

        // Full frame, everything always ready.
        start_frame(32'h2000_0000);
        wait_busy_low("frame_busy");
        check_frame_done("frame");

        // FIFO backpressure after burst 3.
        base = $urandom;
        start_frame(base);
        wait_ar_count(3, "bp_wait3");
        BUF_WREADY = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("bp_no_arvalid", 64'(ARVALID), 64'd0);
        end
        BUF_WREADY = 1'b1;
        tick();
        check("bp_arvalid_next", 64'(ARVALID), 64'd1);
        wait_busy_low("bp_busy");
        check_frame_done("bp");

        // Slow ARREADY, gapped RVALID, VRSTART with a new address mid-frame.
        ar_delay = 7;
        rgap_en  = 1'b1;
        start_frame(32'h0001_2345);
        wait_ar_count(4, "slow_wait4");
        DISPADDR = 32'h3000_0000;
        VRSTART  = 1'b1;
        tick();
        VRSTART  = 1'b0;
        wait_busy_low("slow_busy");
        check_frame_done("slow");
        ar_delay = 0;
        rgap_en  = 1'b0;

        // DISPON drops on beat 5 of burst 10.
        start_frame(32'h8000_0000);
        n = 0;
        while ((r_total - r_base) < 9 * TB_BL + 5 && n < BUDGET) begin
            tick();
            n++;
        end
        if ((r_total - r_base) < 9 * TB_BL + 5) note_fail("off_wait", "beat 5 of burst 10 never seen");
        DISPON = 1'b0;
        wait_busy_low("off_busy");
        repeat (20) tick();
        check("off_bursts", 64'(ar_total - ar_base), 64'd10);
        check("off_writes", 64'(wr_total - wr_base), 64'(10 * TB_BL));
        check("off_addr_left", 64'(exp_addr.size()), 64'(TB_N - 10));
        check("off_data_left", 64'(exp_data.size()), 64'd0);
        check("off_state", 64'(dut.state_q), 64'(IDLE));
        check("off_busy", 64'(BUSY), 64'd0);
        exp_addr.delete();

        // VRSTART while the display is disabled.
        DISPADDR = 32'h5555_0000;
        VRSTART  = 1'b1;
        tick();
        VRSTART  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("dis_no_arvalid", 64'(ARVALID), 64'd0);
            check("dis_no_busy", 64'(BUSY), 64'd0);
            tick();
        end

        // Reset held 3 cycles in the middle of a burst, then a clean restart.
        start_frame(32'h1000_0000);
        wait_ar_count(2, "rst_wait2");
        n = 0;
        while (!RREADY && n < BUDGET) begin
            tick();
            n++;
        end
        repeat (3) tick();
        ARST = 1'b1;
        repeat (3) tick();
        check_reset_outputs("mid_rst");
        ARST = 1'b0;
        exp_addr.delete();
        tick();
        check("rst_data_left", 64'(exp_data.size()), 64'd0);
        start_frame(32'h4000_01FF);
        wait_busy_low("rst_busy");
        check_frame_done("restart");

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
